da_tap_serializer: RTL and testbench

Multi-tap, bit-serial sample front end for the distributed-arithmetic (DA) filter datapath. Holds a TAPS-deep delay line of WIDTH-bit two's-complement samples and, on each accepted input sample, serializes every tap LSB-first in parallel. Each cycle it emits a TAPS-bit LUT address (one bit per tap) with first-bit and sign-bit strobes for the DA accumulator. It generalises the single-lane parallel-load, sign-extending shift register to N lanes and adds a bit counter, a load handshake, a global enable and a history clear.

---
 rtl/da_pkg.sv | 12 +
 rtl/da_ser_lane.sv | 31 +++
 rtl/da_tap_serializer.sv | 111 +++++++++++
 tb/tb_da_tap_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared types and default sizing for the distributed-arithmetic filter datapath.
package da_pkg;

    localparam int unsigned DA_WIDTH = 20;
    localparam int unsigned DA_TAPS  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } da_ser_state_t;

endpackage

// File: rtl/da_ser_lane.sv
// One serializer lane: parallel load, then sign-extending right shift that
// presents one bit per cycle at the LSB.
module da_ser_lane
    import da_pkg::*;
#(
    parameter int unsigned WIDTH = DA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_ser;

    // Load wins over shift so a reload on the final bit starts the next word cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ser <= '0;
        end else if (i_load) begin
            r_ser <= i_data;
        end else if (i_shift) begin
            r_ser <= {r_ser[WIDTH-1], r_ser[WIDTH-1:1]};
        end
    end

    assign o_lsb = r_ser[0];

endmodule

// File: rtl/da_tap_serializer.sv
// TAPS-deep sample delay line feeding TAPS parallel bit-serial lanes; emits one
// DA LUT address bit per tap each cycle with first/sign strobes.
module da_tap_serializer
    import da_pkg::*;
#(
    parameter int unsigned WIDTH = DA_WIDTH,
    parameter int unsigned TAPS  = DA_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             addr_valid,
    output logic [TAPS-1:0]  addr,
    output logic             addr_first,
    output logic             addr_last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    da_ser_state_t    r_state;
    da_ser_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tap    [TAPS];
    logic [WIDTH-1:0] w_lane_d [TAPS];
    logic             w_cnt_last;
    logic             w_load;
    logic             w_shift;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_shift    = en && (r_state == SHIFT);
    assign in_ready   = en && ((r_state == IDLE) || w_cnt_last);
    assign w_load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = SHIFT;
        end else if (w_shift && w_cnt_last) begin
            w_state_nxt = IDLE;
        end
    end

    // Bit counter parks at zero between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Lane k loads the post-shift delay line, so clr zeroes every older tap.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            assign w_lane_d[k] = in_data;
        end else begin : g_tail
            assign w_lane_d[k] = clr ? '0 : r_tap[k-1];
        end

        da_ser_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_data  (w_lane_d[k]),
            .o_lsb   (addr[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_tap[k] <= '0;
            end
        end else if (en) begin
            if (w_load) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_tap[k] <= w_lane_d[k];
                end
            end else if (clr) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_tap[k] <= '0;
                end
            end
        end
    end

    assign addr_valid = w_shift;
    assign addr_first = w_shift && (r_cnt == '0);
    assign addr_last  = w_shift && w_cnt_last;
    assign busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_da_tap_serializer.sv
// Self-checking bench: word-level model of the delay line plus directed and random stimulus.
module tb_da_tap_serializer;

    localparam int W = 8;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           clr;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           addr_valid;
    logic [T-1:0]   addr;
    logic           addr_first;
    logic           addr_last;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    da_tap_serializer #(.WIDTH(W), .TAPS(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_first (addr_first),
        .addr_last  (addr_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Model: sample history and a snapshot of the words being serialized, indexed by bit number.
    logic [W-1:0] m_hist [T];
    logic [W-1:0] m_snap [T];
    bit           m_active = 1'b0;
    int           m_bit    = 0;

    function automatic logic exp_ready();
        return en && (!m_active || m_bit == W - 1);
    endfunction

    function automatic logic [T-1:0] exp_addr();
        logic [T-1:0] a;
        for (int k = 0; k < T; k++) a[k] = m_snap[k][m_bit];
        return a;
    endfunction

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("cyc_in_ready",   32'(in_ready),   32'(exp_ready()));
            check("cyc_addr_valid", 32'(addr_valid), 32'(en && m_active));
            check("cyc_addr",       32'(addr),       32'(exp_addr()));
            check("cyc_addr_first", 32'(addr_first), 32'(en && m_active && m_bit == 0));
            check("cyc_addr_last",  32'(addr_last),  32'(en && m_active && m_bit == W - 1));
            check("cyc_busy",       32'(busy),       32'(m_active));
        end
        // Advance the model with the inputs that the next rising edge will sample.
        if (rst) begin
            for (int k = 0; k < T; k++) begin
                m_hist[k] = '0;
                m_snap[k] = '0;
            end
            m_active = 1'b0;
            m_bit    = 0;
        end else if (en) begin
            if (in_valid && exp_ready()) begin
                for (int k = T - 1; k > 0; k--) m_hist[k] = clr ? '0 : m_hist[k-1];
                m_hist[0] = in_data;
                for (int k = 0; k < T; k++) m_snap[k] = m_hist[k];
                m_active = 1'b1;
                m_bit    = 0;
            end else begin
                if (clr) for (int k = 0; k < T; k++) m_hist[k] = '0;
                if (m_active) begin
                    if (m_bit == W - 1) m_active = 1'b0;
                    else m_bit++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [T-1:0] cap_addr [W];
    logic [W-1:0] cap_first;
    logic [W-1:0] cap_last;

    function automatic logic [W-1:0] lane_word(input int k);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = cap_addr[i][k];
        return w;
    endfunction

    // Load one sample (optionally with clr) and capture its W output cycles.
    task automatic run_pass(input logic [W-1:0] d, input logic c);
        in_valid = 1'b1;
        in_data  = d;
        clr      = c;
        tick();
        in_valid = 1'b0;
        clr      = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            cap_addr[i]  = addr;
            cap_first[i] = addr_first;
            cap_last[i]  = addr_last;
            tick();
        end
    endtask

    initial begin
        int firsts [$];
        int idx;
        int nvalid;
        int last_c;
        logic [T-1:0] hi_or;

        rst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        rst    = 1'b0;
        chk_on = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_addr",       32'(addr),       32'h0);
        tick();

        // Single load of 0x05 into an empty history
        run_pass(8'h05, 1'b0);
        check("single_lane0", 32'(lane_word(0)), 32'h05);
        hi_or = '0;
        for (int i = 0; i < W; i++) hi_or |= cap_addr[i];
        check("single_upper", 32'(hi_or[T-1:1]), 32'h0);
        check("single_first", 32'(cap_first), 32'h01);
        check("single_last",  32'(cap_last),  32'h80);
        @(negedge clk);
        check("single_busy_after", 32'(busy), 32'd0);
        tick();

        // -3 following 0x05: tap 1 carries the previous sample
        run_pass(8'hFD, 1'b0);
        check("neg_lane0", 32'(lane_word(0)), 32'hFD);
        check("neg_lane1", 32'(lane_word(1)), 32'h05);
        check("neg_sign_on_last", 32'(cap_addr[W-1][0]), 32'd1);

        // Back-to-back stream 1,2,3 with in_valid held high
        in_valid = 1'b1;
        in_data  = 8'h01;
        idx      = 0;
        for (int c = 0; c < 40; c++) begin
            logic ld;
            @(negedge clk);
            if (addr_first) firsts.push_back(c);
            if (busy && in_ready) check("stream_ready_on_last", 32'(addr_last), 32'd1);
            ld = in_valid && in_ready;
            tick();
            if (ld) begin
                idx++;
                if (idx == 3) in_valid = 1'b0;
                else in_data = W'(idx + 1);
            end
        end
        check("stream_nfirst", 32'(firsts.size()), 32'd3);
        if (firsts.size() == 3) begin
            check("stream_gap0", 32'(firsts[1] - firsts[0]), 32'd8);
            check("stream_gap1", 32'(firsts[2] - firsts[1]), 32'd8);
        end

        // en low for two cycles after the third bit
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        nvalid   = 0;
        last_c   = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!en) begin
                check("en_low_valid", 32'(addr_valid), 32'd0);
                check("en_low_ready", 32'(in_ready),   32'd0);
            end
            if (c == 5) check("en_resume_bit3", 32'(addr[0]), 32'd1);
            if (addr_valid) nvalid++;
            if (addr_last) last_c = c;
            tick();
            en = !(c == 2 || c == 3);
        end
        en = 1'b1;
        check("en_nvalid", 32'(nvalid), 32'd8);
        check("en_last_at", 32'(last_c), 32'd9);

        // Reset in the middle of a sample, then a fresh load sees empty history
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(addr), 32'h0);
        tick();
        run_pass(8'h05, 1'b0);
        hi_or = '0;
        for (int i = 0; i < W; i++) hi_or |= cap_addr[i];
        check("midrst_upper", 32'(hi_or[T-1:1]), 32'h0);
        check("midrst_lane0", 32'(lane_word(0)), 32'h05);

        // clr together with a load of 0x7F over a non-empty history
        run_pass(8'h44, 1'b0);
        run_pass(8'h7F, 1'b1);
        for (int i = 0; i < W; i++)
            check("clr_load_addr", 32'(cap_addr[i]), (i < W - 1) ? 32'h1 : 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom % 200) == 0;
            en       = ($urandom % 8) != 0;
            clr      = ($urandom % 16) == 0;
            in_valid = ($urandom % 3) != 0;
            in_data  = W'($urandom);
            tick();
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0;
        repeat (W + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
